iir_seq: RTL and testbench
==========================

IIR_SEQ -- requirements
Module: iir_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, meaning the width of the sample-memory address.
REQ-002 SHALL have parameter LEN_W, default 20, meaning the width of the frame-length count.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle frame request.
REQ-006 SHALL have port base_raddr, input, ADDR_W, the first input-sample address.
REQ-007 SHALL have port base_waddr, input, ADDR_W, the first output-sample address.
REQ-008 SHALL have port len, input, LEN_W, the number of samples in the frame.
REQ-009 SHALL have port mem_rvalid, input, 1, which indicates that the read data for RAddr is valid this cycle.
REQ-010 SHALL have port data_done, input, 1, an external abort/end-of-data indication.
REQ-011 SHALL have port load, output, 1, the read request to the input memory.
REQ-012 SHALL have port RAddr, output, ADDR_W, the read address.
REQ-013 SHALL have port filt_clr, output, 1, which clears the IIR filter state registers.
REQ-014 SHALL have port filt_en, output, 1, which advances the filter by one sample.
REQ-015 SHALL have port WEN, output, 1, the output-memory write strobe.
REQ-016 SHALL have port WAddr, output, ADDR_W, the write address.
REQ-017 SHALL have port busy, output, 1, which is high from acceptance of start until Finish.
REQ-018 SHALL have port Finish, output, 1, a one-cycle frame-complete pulse.

Function
REQ-019 SHALL implement the FSM states IDLE, CLEAR, RUN, DRAIN and DONE.
REQ-020 In IDLE, start with len!=0 SHALL go to CLEAR; start with len==0 SHALL go directly to DONE; otherwise the FSM SHALL stay in IDLE.
REQ-021 start SHALL be ignored in any state other than IDLE.
REQ-022 On start acceptance, base_raddr, base_waddr and len SHALL be latched; later changes to them SHALL have no effect on the running frame.
REQ-023 CLEAR SHALL last exactly one cycle with filt_clr=1, read count=0 and write count=0, then go to RUN.
REQ-024 In RUN: load=1 and RAddr=latched base_raddr+read count (modulo 2^ADDR_W).
REQ-025 A sample is accepted in any RUN cycle with load=1 and mem_rvalid=1; that cycle SHALL have filt_en=1 combinationally, and the read count SHALL increment.
REQ-026 The FSM SHALL go from RUN to DRAIN on acceptance of sample len-1, or in any RUN cycle with data_done=1; a sample accepted in that same cycle SHALL still be processed.
REQ-027 WEN SHALL pulse exactly one cycle after each accepted sample, with WAddr=latched base_waddr+write count (modulo 2^ADDR_W), and the write count SHALL increment after each write.
REQ-028 DRAIN SHALL last exactly one cycle, covering the final write, then go to DONE.
REQ-029 DONE SHALL drive Finish=1 for one cycle, then go to IDLE.
REQ-030 busy SHALL be 1 in CLEAR, RUN and DRAIN, and 0 in IDLE and DONE.
REQ-031 load, filt_en and filt_clr SHALL be 0 outside RUN and CLEAR respectively.
REQ-032 Address wrap-around past 2^ADDR_W-1 SHALL roll over to 0 with no error.
REQ-033 Total writes per frame SHALL equal total accepted samples.
REQ-034 Best-case latency from start to Finish SHALL be len+3 cycles.

Reset
REQ-035 On rst=1 at a clock edge, the FSM SHALL go to IDLE and the counters and latched values SHALL be cleared.
REQ-036 While in reset, load, filt_clr, filt_en, WEN, busy and Finish SHALL be 0, and RAddr and WAddr SHALL be 0.
REQ-037 Reset mid-frame SHALL abandon the frame with no Finish pulse and no further writes; the next start SHALL begin a fresh CLEAR.

Configuration
REQ-038 When IIR_SEQ_STALL_EN is defined, mem_rvalid SHALL gate sample acceptance as described in REQ-025.
REQ-039 When IIR_SEQ_STALL_EN is undefined, mem_rvalid SHALL be ignored and every RUN cycle SHALL accept a sample, giving exactly len+3 cycles per frame.

Structure
REQ-040 Package iir_pkg SHALL hold the ADDR_W and LEN_W defaults and the FSM state typedef iir_seq_state_t.
REQ-041 A sub-module iir_addr_gen (base latch, counter and adder, clear and increment) SHALL be instantiated twice, once for read addressing and once for write addressing.

Verification
REQ-042 Case: base_raddr=0x00010, base_waddr=0x00100, len=4, mem_rvalid=1 -> RAddr 0x10..0x13, WEN pulses at WAddr 0x100..0x103, Finish in cycle 7 after start.
REQ-043 Case: len=3 with mem_rvalid low for 2 cycles after the first sample -> RAddr holds at base+1 during the stall, filt_en gets 3 pulses, 3 writes, Finish at cycle 8.
REQ-044 Case: len=0 -> Finish pulses one cycle after start, with no load, filt_clr or WEN activity.
REQ-045 Case: base_raddr=0xFFFFE, len=4 -> RAddr sequence 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
REQ-046 Case: len=10 with data_done asserted in the same cycle as the 5th accepted sample -> exactly 5 writes, then DRAIN, then Finish.
REQ-047 Case: rst asserted in the 3rd RUN cycle of a len=8 frame -> all outputs 0 the next cycle, no Finish, and a following start with len=2 completes normally.

Source files
------------

// File: rtl/iir_pkg.sv
// ----------------------------------------------------------------------------
// iir_pkg
// Shared definitions for the IIR frame sequencer: default address and
// frame-length widths, and the sequencer FSM state type.
// ----------------------------------------------------------------------------
package iir_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int LEN_W_DEF  = 20;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } iir_seq_state_t;

endpackage : iir_pkg

// File: rtl/iir_addr_gen.sv
// ----------------------------------------------------------------------------
// iir_addr_gen
// Base-plus-offset address generator. The base is captured on 'latch', the
// offset counter is zeroed on 'clr' and advanced on 'inc'. The address is the
// modulo-2^W sum, so it rolls over past the top of memory without error.
//
// Ports
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset (clears base and counter)
//   latch : capture 'base'
//   base  : base address to capture
//   clr   : zero the offset counter (has priority over inc)
//   inc   : advance the offset counter by one
//   addr  : base + offset
// ----------------------------------------------------------------------------
module iir_addr_gen #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         latch,
    input  logic [W-1:0] base,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] addr
);

    logic [W-1:0] base_q;
    logic [W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (latch) begin
                base_q <= base;
            end
            if (clr) begin
                cnt_q <= '0;
            end else if (inc) begin
                cnt_q <= cnt_q + W'(1);
            end
        end
    end

    // Truncating add gives the wrap-around at 2^W for free.
    assign addr = base_q + cnt_q;

endmodule : iir_addr_gen

// File: rtl/iir_seq.sv
// ----------------------------------------------------------------------------
// iir_seq
// Frame sequencer for a streaming IIR filter. On 'start' it clears the filter
// state, reads 'len' samples from consecutive input addresses, advances the
// filter once per accepted sample, and writes each result one cycle later to
// consecutive output addresses. A frame ends after the last sample or early
// on 'data_done'; 'Finish' then pulses for one cycle.
//
// Build option
//   IIR_SEQ_STALL_EN : when defined, a RUN cycle accepts a sample only if
//                      mem_rvalid is high; when undefined, mem_rvalid is
//                      ignored and every RUN cycle accepts a sample.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   start      : one-cycle frame request (honoured only in IDLE)
//   base_raddr : first input-sample address   (latched on start)
//   base_waddr : first output-sample address  (latched on start)
//   len        : samples in frame             (latched on start)
//   mem_rvalid : read data for RAddr valid this cycle
//   data_done  : external abort / end of data, ends RUN
//   load       : read request (high throughout RUN)
//   RAddr      : read address
//   filt_clr   : clear filter state (CLEAR cycle)
//   filt_en    : advance filter (combinational, = sample accepted)
//   WEN        : output write strobe, one cycle after each accepted sample
//   WAddr      : write address
//   busy       : high in CLEAR, RUN and DRAIN
//   Finish     : one-cycle frame-complete pulse (DONE)
// ----------------------------------------------------------------------------
module iir_seq
    import iir_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_raddr,
    input  logic [ADDR_W-1:0] base_waddr,
    input  logic [LEN_W-1:0]  len,
    input  logic              mem_rvalid,
    input  logic              data_done,
    output logic              load,
    output logic [ADDR_W-1:0] RAddr,
    output logic              filt_clr,
    output logic              filt_en,
    output logic              WEN,
    output logic [ADDR_W-1:0] WAddr,
    output logic              busy,
    output logic              Finish
);

    iir_seq_state_t   state;
    logic [LEN_W-1:0] remain;    // samples still to accept in this frame
    logic             accept;
    logic             start_ok;
    logic             in_clear;

    // load is registered and high exactly in RUN, so it doubles as "in RUN".
`ifdef IIR_SEQ_STALL_EN
    assign accept = load & mem_rvalid;
`else
    assign accept = load;
    logic unused_rvalid;
    assign unused_rvalid = mem_rvalid;
`endif

    assign filt_en  = accept;
    assign start_ok = (state == IDLE) && start;
    assign in_clear = (state == CLEAR);

    // Single FSM block; every output is registered alongside the state so
    // each one is valid for exactly the cycles its target state lasts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            remain   <= '0;
            load     <= 1'b0;
            filt_clr <= 1'b0;
            WEN      <= 1'b0;
            busy     <= 1'b0;
            Finish   <= 1'b0;
        end else begin
            WEN      <= accept;
            load     <= 1'b0;
            filt_clr <= 1'b0;
            busy     <= 1'b0;
            Finish   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state    <= CLEAR;
                            remain   <= len;
                            filt_clr <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state  <= DONE;
                            Finish <= 1'b1;
                        end
                    end
                end

                CLEAR: begin
                    state <= RUN;
                    load  <= 1'b1;
                    busy  <= 1'b1;
                end

                RUN: begin
                    busy <= 1'b1;
                    if (accept) begin
                        remain <= remain - LEN_W'(1);
                    end
                    // A sample accepted in the exit cycle is still written
                    // during DRAIN via the registered WEN above.
                    if ((accept && remain == LEN_W'(1)) || data_done) begin
                        state <= DRAIN;
                    end else begin
                        load <= 1'b1;
                    end
                end

                DRAIN: begin
                    state  <= DONE;
                    Finish <= 1'b1;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    iir_addr_gen #(.W(ADDR_W)) u_rd_addr (
        .clk   (clk),
        .rst   (rst),
        .latch (start_ok),
        .base  (base_raddr),
        .clr   (in_clear),
        .inc   (accept),
        .addr  (RAddr)
    );

    iir_addr_gen #(.W(ADDR_W)) u_wr_addr (
        .clk   (clk),
        .rst   (rst),
        .latch (start_ok),
        .base  (base_waddr),
        .clr   (in_clear),
        .inc   (WEN),
        .addr  (WAddr)
    );

endmodule : iir_seq

// File: tb/tb_iir_seq.sv
// ----------------------------------------------------------------------------
// tb_iir_seq
// Directed self-checking bench for iir_seq. Each frame is described by its
// stimulus (bases, length, rvalid stall window, data_done / rst / restart
// cycles) and hand-computed expectations. Cycle 'rel' 0 is the cycle in which
// start is driven; outputs are sampled on the falling edge of each cycle.
// ----------------------------------------------------------------------------
module tb_iir_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] base_raddr;
    logic [19:0] base_waddr;
    logic [19:0] len;
    logic        mem_rvalid;
    logic        data_done;
    logic        load;
    logic [19:0] RAddr;
    logic        filt_clr;
    logic        filt_en;
    logic        WEN;
    logic [19:0] WAddr;
    logic        busy;
    logic        Finish;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iir_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_raddr (base_raddr),
        .base_waddr (base_waddr),
        .len        (len),
        .mem_rvalid (mem_rvalid),
        .data_done  (data_done),
        .load       (load),
        .RAddr      (RAddr),
        .filt_clr   (filt_clr),
        .filt_en    (filt_en),
        .WEN        (WEN),
        .WAddr      (WAddr),
        .busy       (busy),
        .Finish     (Finish)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one frame; -1 disables the sf/st, dd_rel, rst_rel and restart_rel
    // events, and exp_fin=-1 means no Finish pulse is expected.
    task automatic run_frame(
        input string       name,
        input logic [19:0] rb,
        input logic [19:0] wb,
        input int          ln,
        input int          sf,
        input int          st,
        input int          dd_rel,
        input int          rst_rel,
        input int          restart_rel,
        input int          max_rel,
        input int          exp_fin,
        input int          exp_load,
        input int          exp_clr,
        input int          exp_busy,
        input int          exp_acc,
        input int          exp_wr
    );
        int          fin_rel = -1;
        int          fin_n   = 0;
        int          load_n  = 0;
        int          clr_n   = 0;
        int          busy_n  = 0;
        logic [19:0] rq[$];
        logic [19:0] wq[$];
        logic [19:0] ea;

        @(posedge clk);
        #1;
        for (int rel = 0; rel <= max_rel; rel++) begin
            if (rel > 0) begin
                @(posedge clk);
                #1;
            end
            // Inputs other than at rel 0 are scrambled to prove they were latched.
            start      = (rel == 0) || (rel == restart_rel);
            base_raddr = (rel == 0) ? rb : 20'hAAAAA;
            base_waddr = (rel == 0) ? wb : 20'h55555;
            len        = (rel == 0) ? 20'(ln) : 20'd1;
            mem_rvalid = !(rel >= sf && rel <= st);
            data_done  = (rel == dd_rel);
            rst        = (rel == rst_rel);

            @(negedge clk);
            if (load)     load_n++;
            if (filt_clr) clr_n++;
            if (busy)     busy_n++;
            if (filt_en)  rq.push_back(RAddr);
            if (WEN)      wq.push_back(WAddr);
            if (Finish) begin
                fin_n++;
                fin_rel = rel;
            end
            if (rel == 3 && ln >= 2)
                check($sformatf("%s raddr_rel3", name), 64'(RAddr), 64'(rb + 20'd1));
            if (rst_rel >= 0 && rel == rst_rel + 1)
                check($sformatf("%s outs_after_rst", name),
                      64'({load, filt_clr, filt_en, WEN, busy, Finish, RAddr, WAddr}), 64'd0);
            if (fin_n > 0) break;
        end
        start     = 1'b0;
        data_done = 1'b0;
        rst       = 1'b0;

        check($sformatf("%s finish_cycle", name), 64'(fin_rel), 64'(exp_fin));
        check($sformatf("%s load_cycles", name),  64'(load_n),  64'(exp_load));
        check($sformatf("%s clr_cycles", name),   64'(clr_n),   64'(exp_clr));
        check($sformatf("%s busy_cycles", name),  64'(busy_n),  64'(exp_busy));
        check($sformatf("%s accepts", name),      64'(rq.size()), 64'(exp_acc));
        check($sformatf("%s writes", name),       64'(wq.size()), 64'(exp_wr));
        for (int i = 0; i < rq.size() && i < exp_acc; i++) begin
            ea = rb + 20'(i);
            check($sformatf("%s raddr[%0d]", name, i), 64'(rq[i]), 64'(ea));
        end
        for (int i = 0; i < wq.size() && i < exp_wr; i++) begin
            ea = wb + 20'(i);
            check($sformatf("%s waddr[%0d]", name, i), 64'(wq[i]), 64'(ea));
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_raddr = '0;
        base_waddr = '0;
        len        = '0;
        mem_rvalid = 1'b1;
        data_done  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({load, filt_clr, filt_en, WEN, busy, Finish, RAddr, WAddr}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // name, rb, wb, len, sf, st, dd, rst, restart, max, fin, load, clr, busy, acc, wr
        run_frame("basic", 20'h00010, 20'h00100, 4, -1, -1, -1, -1, 3, 20,
                  7, 4, 1, 6, 4, 4);
`ifdef IIR_SEQ_STALL_EN
        run_frame("stall", 20'h00200, 20'h00300, 3, 3, 4, -1, -1, -1, 20,
                  8, 5, 1, 7, 3, 3);
`else
        run_frame("stall", 20'h00200, 20'h00300, 3, 3, 4, -1, -1, -1, 20,
                  6, 3, 1, 5, 3, 3);
`endif
        run_frame("len0", 20'h00400, 20'h00500, 0, -1, -1, -1, -1, -1, 20,
                  1, 0, 0, 0, 0, 0);
        run_frame("wrap", 20'hFFFFE, 20'hFFFFF, 4, -1, -1, -1, -1, -1, 20,
                  7, 4, 1, 6, 4, 4);
        run_frame("data_done", 20'h01000, 20'h02000, 10, -1, -1, 6, -1, -1, 30,
                  8, 5, 1, 7, 5, 5);
        run_frame("mid_reset", 20'h03000, 20'h04000, 8, -1, -1, -1, 4, -1, 15,
                  -1, 3, 1, 4, 3, 2);
        run_frame("after_reset", 20'h05000, 20'h06000, 2, -1, -1, -1, -1, -1, 20,
                  5, 2, 1, 4, 2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_iir_seq
